// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control and memory signals of the fetch stage.
// master: drives start/stall/branch and returns imem_rdata; observes the IF/ID outputs.
// slave: the fetch stage itself.
interface instruction_fetch_if #(
    parameter int PC_WIDTH = 32
);
    logic                start;
    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                imem_en;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic [31:0]         instr_out;
    logic [PC_WIDTH-1:0] pc_out;
    logic                valid_out;
    logic                halted;
    logic [15:0]         fetch_count;

    modport master (
        output start, stall, branch_taken, branch_target, imem_rdata,
        input  imem_en, imem_addr, instr_out, pc_out, valid_out, halted, fetch_count
    );

    modport slave (
        input  start, stall, branch_taken, branch_target, imem_rdata,
        output imem_en, imem_addr, instr_out, pc_out, valid_out, halted, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, instruction-memory read and IF/ID pipeline register.
// clk, reset_n (async, active-low); bus (slave): start/stall/branch inputs,
// imem_en/imem_addr/imem_rdata memory port, instr_out/pc_out/valid_out IF/ID outputs,
// halted status and saturating fetch_count.
module instruction_fetch #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  PC_INC     = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]         NOP_INSTR  = 32'hF000_0000,
    parameter logic [31:0]         HALT_INSTR = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    reset_n,
    instruction_fetch_if.slave     bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [15:0]         fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pc_out_q      <= '0;
            instr_q       <= NOP_INSTR;
            valid_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_out_q      <= pc_out_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_out_d      = pc_out_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                // Redirect outranks stall so a resolved branch is never lost behind a hazard.
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    if (bus.imem_rdata == HALT_INSTR) begin
                        state_d = HALTED;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else begin
                        instr_d       = bus.imem_rdata;
                        pc_out_d      = pc_q;
                        valid_d       = 1'b1;
                        pc_d          = pc_q + PC_WIDTH'(PC_INC);
                        fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;
                    end
                end
            end
            HALTED: if (bus.start) begin
                state_d       = RUN;
                pc_d          = RESET_PC;
                fetch_count_d = '0;
            end
            default: begin
                state_d = IDLE;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_en     = (state_q == RUN);
    assign bus.imem_addr   = pc_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.valid_out   = valid_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scenario tasks plus randomized run against a behavioural fetch model.
module tb_instruction_fetch;
    localparam logic [31:0] NOP = 32'hF000_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] halt_addr = 32'hFFFF_FFF0;
    int checks = 0;
    int errors = 0;

    instruction_fetch_if #(.PC_WIDTH(32)) bus ();

    instruction_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_fn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hA822_1000;
            32'h4:   return 32'hA843_1000;
            32'h8:   return 32'hA864_1000;
            default: return ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF) | 32'h1;
        endcase
    endfunction

    assign bus.imem_rdata = (bus.imem_addr == halt_addr) ? 32'h0 : word_fn(bus.imem_addr);

    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pcout;
    logic        m_valid;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = NOP; m_pcout = 0; m_valid = 0; m_cnt = 0;
    endtask

    // Advance model by one edge using current inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] rd;
        rd = (m_pc == halt_addr) ? 32'h0 : word_fn(m_pc);
        if (m_mode == 0) begin
            if (bus.start) m_mode = 1;
        end else if (m_mode == 2) begin
            if (bus.start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_target; m_instr = NOP; m_valid = 0;
        end else if (bus.stall) begin
        end else if (rd == 32'h0) begin
            m_mode = 2; m_instr = NOP; m_valid = 0;
        end else begin
            m_instr = rd; m_pcout = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        reset_n = 0;
        model_reset();
        #12;
        checks++;
        if (bus.instr_out !== NOP || bus.valid_out !== 1'b0 || bus.pc_out !== 32'h0 ||
            bus.fetch_count !== 16'h0 || bus.halted !== 1'b0 || bus.imem_en !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset: instr=%h valid=%b pc_out=%h cnt=%h halted=%b en=%b addr=%h required NOP/0/0/0/0/0/0",
                     bus.instr_out, bus.valid_out, bus.pc_out, bus.fetch_count, bus.halted, bus.imem_en, bus.imem_addr);
        end
        reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        bus.start = 1;
        tick();
        bus.start = 0;
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL start: en=%b addr=%h valid=%b required 1/0/0", bus.imem_en, bus.imem_addr, bus.valid_out);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.instr_out !== word_fn(32'(i * 4)) || bus.pc_out !== 32'(i * 4) ||
                bus.valid_out !== 1'b1 || bus.fetch_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL fetch%0d: instr=%h pc_out=%h valid=%b cnt=%0d required %h/%h/1/%0d",
                         i, bus.instr_out, bus.pc_out, bus.valid_out, bus.fetch_count, word_fn(32'(i * 4)), i * 4, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.instr_out !== 32'hA843_1000 || bus.pc_out !== 32'h4 || bus.fetch_count !== 16'd2 || bus.imem_addr !== 32'h8) begin
                errors++;
                $display("FAIL stall%0d: instr=%h pc_out=%h cnt=%0d addr=%h required A8431000/4/2/8",
                         i, bus.instr_out, bus.pc_out, bus.fetch_count, bus.imem_addr);
            end
        end
        bus.stall = 0;
        tick();
        checks++;
        if (bus.instr_out !== 32'hA864_1000 || bus.pc_out !== 32'h8 || bus.fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL stall_release: instr=%h pc_out=%h cnt=%0d required A8641000/8/3", bus.instr_out, bus.pc_out, bus.fetch_count);
        end
    endtask

    task automatic test_halt();
        halt_addr = 32'h10;
        tick();
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.imem_en !== 1'b0 || bus.imem_addr !== 32'h10 ||
            bus.valid_out !== 1'b0 || bus.instr_out !== NOP || bus.fetch_count !== 16'd4) begin
            errors++;
            $display("FAIL halt: halted=%b en=%b addr=%h valid=%b instr=%h cnt=%0d required 1/0/10/0/NOP/4",
                     bus.halted, bus.imem_en, bus.imem_addr, bus.valid_out, bus.instr_out, bus.fetch_count);
        end
        bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h80;
        tick();
        bus.stall = 0; bus.branch_taken = 0;
        checks++;
        if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL halt_ignore: halted=%b addr=%h required 1/10", bus.halted, bus.imem_addr);
        end
        halt_addr = 32'hFFFF_FFF0;
        bus.start = 1;
        tick();
        bus.start = 0;
        checks++;
        if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h0 || bus.fetch_count !== 16'd0 || bus.imem_en !== 1'b1) begin
            errors++;
            $display("FAIL restart: halted=%b addr=%h cnt=%0d en=%b required 0/0/0/1", bus.halted, bus.imem_addr, bus.fetch_count, bus.imem_en);
        end
        tick();
        checks++;
        if (bus.instr_out !== 32'hA822_1000 || bus.fetch_count !== 16'd1) begin
            errors++;
            $display("FAIL restart_fetch: instr=%h cnt=%0d required A8221000/1", bus.instr_out, bus.fetch_count);
        end
    endtask

    task automatic test_branch();
        bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h40;
        tick();
        bus.stall = 0; bus.branch_taken = 0;
        checks++;
        if (bus.instr_out !== NOP || bus.valid_out !== 1'b0 || bus.imem_addr !== 32'h40 || bus.fetch_count !== 16'd1) begin
            errors++;
            $display("FAIL branch_bubble: instr=%h valid=%b addr=%h cnt=%0d required NOP/0/40/1",
                     bus.instr_out, bus.valid_out, bus.imem_addr, bus.fetch_count);
        end
        tick();
        checks++;
        if (bus.instr_out !== word_fn(32'h40) || bus.pc_out !== 32'h40 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL branch_target: instr=%h pc_out=%h valid=%b required %h/40/1", bus.instr_out, bus.pc_out, bus.valid_out, word_fn(32'h40));
        end
    endtask

    task automatic test_wrap();
        bus.branch_taken = 1; bus.branch_target = 32'hFFFF_FFFC;
        tick();
        bus.branch_taken = 0;
        tick();
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.pc_out !== 32'hFFFF_FFFC || bus.instr_out !== word_fn(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap: addr=%h pc_out=%h instr=%h required 0/FFFFFFFC/%h", bus.imem_addr, bus.pc_out, bus.instr_out, word_fn(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_saturate();
        force dut.fetch_count_q = 16'hFFFE;
        #1;
        release dut.fetch_count_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.fetch_count !== 16'hFFFF) begin
                errors++;
                $display("FAIL saturate%0d: cnt=%h required FFFF", i, bus.fetch_count);
            end
        end
    endtask

    task automatic test_random();
        halt_addr = 32'h100;
        for (int n = 0; n < 400; n++) begin
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.branch_taken  = ($urandom_range(0, 9) == 0);
            bus.branch_target = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
            bus.start         = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (bus.instr_out !== m_instr || bus.pc_out !== m_pcout || bus.valid_out !== m_valid ||
                bus.fetch_count !== m_cnt || bus.imem_addr !== m_pc ||
                bus.imem_en !== (m_mode == 1) || bus.halted !== (m_mode == 2)) begin
                errors++;
                $display("FAIL random%0d: instr=%h pc_out=%h valid=%b cnt=%h addr=%h en=%b halted=%b required %h/%h/%b/%h/%h/%b/%b",
                         n, bus.instr_out, bus.pc_out, bus.valid_out, bus.fetch_count, bus.imem_addr, bus.imem_en, bus.halted,
                         m_instr, m_pcout, m_valid, m_cnt, m_pc, m_mode == 1, m_mode == 2);
            end
        end
        bus.stall = 0; bus.branch_taken = 0; bus.start = 0;
        halt_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_reset_mid();
        bus.branch_taken = 1; bus.branch_target = 32'h20;
        tick();
        bus.branch_taken = 0;
        if (m_mode != 1) begin
            bus.start = 1;
            tick();
            bus.start = 0;
        end
        tick();
        #3;
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (bus.instr_out !== NOP || bus.valid_out !== 1'b0 || bus.pc_out !== 32'h0 ||
            bus.imem_addr !== 32'h0 || bus.imem_en !== 1'b0 || bus.fetch_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: instr=%h valid=%b pc_out=%h addr=%h en=%b cnt=%h required NOP/0/0/0/0/0",
                     bus.instr_out, bus.valid_out, bus.pc_out, bus.imem_addr, bus.imem_en, bus.fetch_count);
        end
        #2;
        reset_n = 1;
        @(posedge clk); #1;
        bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        checks++;
        if (bus.instr_out !== 32'hA822_1000 || bus.pc_out !== 32'h0 || bus.valid_out !== 1'b1 || bus.fetch_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_refetch: instr=%h pc_out=%h valid=%b cnt=%0d required A8221000/0/1/1",
                     bus.instr_out, bus.pc_out, bus.valid_out, bus.fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_halt();
        test_branch();
        test_wrap();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
